// File: rtl/aurora_64b66b_25p78g_qpll_reset_ctrl_pkg.sv
// Shared types and constants for the QPLL0 reset sequencer.
package aurora_64b66b_25p78g_qpll_reset_ctrl_pkg;

    // Encodings are also the debug codes presented on o_state_dbg.
    typedef enum logic [2:0] {
        ST_RESET_HOLD  = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_STABLE      = 3'd2,
        ST_READY       = 3'd3,
        ST_WAIT_REFCLK = 3'd4
    } qpll_state_e;

    localparam int unsigned DEF_RESET_CYCLES = 128;
    localparam int unsigned DEF_LOCK_TIMEOUT = 65536;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;

    function automatic int unsigned f_clog2(input int unsigned val);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(val)) r++;
        return r;
    endfunction

    function automatic int unsigned f_max3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
        int unsigned m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/aurora_64b66b_25p78g_qpll_reset_ctrl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into init_clk.
module aurora_64b66b_25p78g_qpll_reset_ctrl_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic init_clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/aurora_64b66b_25p78g_qpll_reset_ctrl.sv
// QPLL0 reset sequencer and lock monitor.
//   state          | meaning
//   RESET_HOLD     | qpll0_reset asserted for RESET_CYCLES
//   WAIT_LOCK      | reset released, waiting for lock (bounded by LOCK_TIMEOUT)
//   STABLE         | lock seen, counting LOCK_STABLE consecutive lock cycles
//   READY          | qpll_ready asserted, monitoring lock/refclk/requests
//   WAIT_REFCLK    | reference clock lost, PLL held in reset until it returns
module aurora_64b66b_25p78g_qpll_reset_ctrl
    import aurora_64b66b_25p78g_qpll_reset_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic             init_clk,
    input  logic             reset_n,
    input  logic             i_qpll0_lock,
    input  logic             i_qpll0_refclklost,
    input  logic             i_pll_reset_req,
    output logic             o_qpll0_reset,
    output logic             o_qpll_ready,
    output logic             o_lock_timeout_err,
    output logic [CNT_W-1:0] o_relock_count,
    output logic [2:0]       o_state_dbg
);

    localparam int unsigned TW = f_clog2(f_max3(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));
    localparam logic [TW-1:0]    TC_RESET  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0]    TC_LOCK   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    TC_STABLE = TW'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             w_lock_s;
    logic             w_lost_s;
    qpll_state_e      r_state;
    qpll_state_e      w_state_nxt;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nxt;
    logic             w_relock;
    logic             w_timeout;
    logic             r_qpll0_reset;
    logic             r_qpll_ready;
    logic             r_lock_timeout_err;
    logic [CNT_W-1:0] r_relock_count;

    aurora_64b66b_25p78g_qpll_reset_ctrl_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .init_clk (init_clk),
        .reset_n  (reset_n),
        .i_async  (i_qpll0_lock),
        .o_sync   (w_lock_s)
    );

    aurora_64b66b_25p78g_qpll_reset_ctrl_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lost (
        .init_clk (init_clk),
        .reset_n  (reset_n),
        .i_async  (i_qpll0_refclklost),
        .o_sync   (w_lost_s)
    );

    // Next-state decode: refclk loss beats a reset request, which beats the local rules.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_relock    = 1'b0;
        w_timeout   = 1'b0;
        if (w_lost_s) begin
            w_state_nxt = ST_WAIT_REFCLK;
            w_timer_nxt = '0;
        end else if (i_pll_reset_req) begin
            // A request during RESET_HOLD only restarts the hold; it is not a new re-sequence.
            w_state_nxt = ST_RESET_HOLD;
            w_timer_nxt = '0;
            w_relock    = (r_state != ST_RESET_HOLD);
        end else begin
            case (r_state)
                ST_RESET_HOLD: begin
                    if (r_timer == TC_RESET) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == TC_LOCK) begin
                        w_state_nxt = ST_RESET_HOLD;
                        w_timer_nxt = '0;
                        w_timeout   = 1'b1;
                        w_relock    = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else if (r_timer == TC_STABLE) begin
                        w_state_nxt = ST_READY;
                        w_timer_nxt = '0;
                    end
                end
                ST_READY: begin
                    w_timer_nxt = '0;
                    if (!w_lock_s) begin
                        w_state_nxt = ST_RESET_HOLD;
                        w_relock    = 1'b1;
                    end
                end
                ST_WAIT_REFCLK: begin
                    w_state_nxt = ST_RESET_HOLD;
                    w_timer_nxt = '0;
                    w_relock    = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_RESET_HOLD;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // State, timer and registered outputs, all derived from the next state.
    always_ff @(posedge init_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ST_RESET_HOLD;
            r_timer            <= '0;
            r_qpll0_reset      <= 1'b1;
            r_qpll_ready       <= 1'b0;
            r_lock_timeout_err <= 1'b0;
            r_relock_count     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_qpll0_reset <= (w_state_nxt == ST_RESET_HOLD) || (w_state_nxt == ST_WAIT_REFCLK);
            r_qpll_ready  <= (w_state_nxt == ST_READY);
            if (w_timeout) r_lock_timeout_err <= 1'b1;
            if (w_relock && (r_relock_count != CNT_MAX)) r_relock_count <= r_relock_count + 1'b1;
        end
    end

    assign o_qpll0_reset      = r_qpll0_reset;
    assign o_qpll_ready       = r_qpll_ready;
    assign o_lock_timeout_err = r_lock_timeout_err;
    assign o_relock_count     = r_relock_count;
    assign o_state_dbg        = r_state;

endmodule

// File: tb/tb_aurora_64b66b_25p78g_qpll_reset_ctrl.sv
// Directed bench for the QPLL0 reset sequencer with a scoreboard of expected values.
module tb_aurora_64b66b_25p78g_qpll_reset_ctrl;

    localparam int RC = 8;
    localparam int LT = 64;
    localparam int LS = 16;

    localparam int SIG_RST  = 0;
    localparam int SIG_RDY  = 1;
    localparam int SIG_ERR  = 2;
    localparam int SIG_ST   = 3;
    localparam int SIG_CNT  = 4;
    localparam int SIG_SCNT = 5;

    logic       init_clk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       lock     = 1'b0;
    logic       lost     = 1'b0;
    logic       req      = 1'b0;
    logic       q_rst, q_rdy, q_err;
    logic [7:0] q_cnt;
    logic [2:0] q_st;
    logic       s_rst, s_rdy, s_err;
    logic [1:0] s_cnt;
    logic [2:0] s_st;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;

    always #5 init_clk = ~init_clk;

    aurora_64b66b_25p78g_qpll_reset_ctrl #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .CNT_W(8), .SYNC_STAGES(2)
    ) dut (
        .init_clk           (init_clk),
        .reset_n            (reset_n),
        .i_qpll0_lock       (lock),
        .i_qpll0_refclklost (lost),
        .i_pll_reset_req    (req),
        .o_qpll0_reset      (q_rst),
        .o_qpll_ready       (q_rdy),
        .o_lock_timeout_err (q_err),
        .o_relock_count     (q_cnt),
        .o_state_dbg        (q_st)
    );

    aurora_64b66b_25p78g_qpll_reset_ctrl #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .CNT_W(2), .SYNC_STAGES(2)
    ) dut_sat (
        .init_clk           (init_clk),
        .reset_n            (reset_n),
        .i_qpll0_lock       (lock),
        .i_qpll0_refclklost (lost),
        .i_pll_reset_req    (req),
        .o_qpll0_reset      (s_rst),
        .o_qpll_ready       (s_rdy),
        .o_lock_timeout_err (s_err),
        .o_relock_count     (s_cnt),
        .o_state_dbg        (s_st)
    );

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            SIG_RST:  return 32'(q_rst);
            SIG_RDY:  return 32'(q_rdy);
            SIG_ERR:  return 32'(q_err);
            SIG_ST:   return 32'(q_st);
            SIG_CNT:  return 32'(q_cnt);
            SIG_SCNT: return 32'(s_cnt);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic tick();
        @(posedge init_clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%0d expected=entry", obs);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    // Counts edges until the selected output reaches val; an expired bound is a failure.
    task automatic edges_until(input int sel, input logic [31:0] val, input int max_edges,
                               output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while ((sig(sel) !== val) && (cnt < max_edges));
        n_checks++;
        assert (sig(sel) === val) else begin
            n_fail++;
            $error("FAIL wait_sel%0d observed=%0d expected=%0d", sel, sig(sel), val);
        end
    endtask

    task automatic check_reset_values(input string who);
        push({who, "_qpll0_reset"}, 1);     check(32'(q_rst));
        push({who, "_qpll_ready"}, 0);      check(32'(q_rdy));
        push({who, "_timeout_err"}, 0);     check(32'(q_err));
        push({who, "_state"}, 0);           check(32'(q_st));
        push({who, "_relock_count"}, 0);    check(32'(q_cnt));
        push({who, "_sat_relock_count"}, 0); check(32'(s_cnt));
        push({who, "_sat_qpll0_reset"}, 1); check(32'(s_rst));
        push({who, "_sat_ready"}, 0);       check(32'(s_rdy));
        push({who, "_sat_err"}, 0);         check(32'(s_err));
        push({who, "_sat_state"}, 0);       check(32'(s_st));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up with lock already present.
        reset_n = 1'b0;
        lock    = 1'b1;
        repeat (3) tick();
        check_reset_values("por");
        reset_n = 1'b1;
        push("pwr_reset_high_cycles", RC);
        edges_until(SIG_RST, 0, 50, n);
        check(32'(n));
        push("pwr_state_wait_lock", 1);
        check(32'(q_st));
        push("pwr_ready_after_reset_fall", 1 + LS);
        edges_until(SIG_RDY, 1, 100, n);
        check(32'(n));
        push("pwr_state_ready", 3);  check(32'(q_st));
        push("pwr_relock_count", 0); check(32'(q_cnt));
        push("pwr_err", 0);          check(32'(q_err));

        // Request and synchronized lock loss seen by the FSM in the same cycle.
        lock = 1'b0;
        tick();
        tick();
        push("sim_still_ready", 1);
        check(32'(q_rdy));
        req = 1'b1;
        push("sim_state_reset_hold", 0);
        push("sim_relock_count", 1);
        push("sim_qpll0_reset", 1);
        push("sim_ready_dropped", 0);
        tick();
        req  = 1'b0;
        lock = 1'b1;
        check(32'(q_st));
        check(32'(q_cnt));
        check(32'(q_rst));
        check(32'(q_rdy));
        push("sim_reset_high_cycles", RC);
        edges_until(SIG_RST, 0, 50, n);
        check(32'(n));
        push("sim_single_increment", 1);
        check(32'(q_cnt));

        // One-cycle lock glitch while STABLE is at count 10.
        push("glitch_edges_to_stable", 1);
        edges_until(SIG_ST, 2, 20, n);
        check(32'(n));
        repeat (8) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        tick();
        push("glitch_still_stable", 2);
        check(32'(q_st));
        tick();
        push("glitch_back_to_wait_lock", 1);
        check(32'(q_st));
        tick();
        push("glitch_stable_again", 2);
        check(32'(q_st));
        push("glitch_full_stable_count", LS);
        edges_until(SIG_RDY, 1, 100, n);
        check(32'(n));
        push("glitch_relock_unchanged", 1);
        check(32'(q_cnt));

        // Reference clock lost for 50 cycles while READY.
        lost = 1'b1;
        push("lost_ready_drop_edges", 3);
        edges_until(SIG_RDY, 0, 10, n);
        check(32'(n));
        push("lost_qpll0_reset", 1);   check(32'(q_rst));
        push("lost_state_refclk", 4);  check(32'(q_st));
        repeat (47) tick();
        push("lost_hold_state", 4);    check(32'(q_st));
        push("lost_hold_count", 1);    check(32'(q_cnt));
        lost = 1'b0;
        push("lost_clear_edges", 3);
        edges_until(SIG_ST, 0, 10, n);
        check(32'(n));
        push("lost_relock_count", 2);  check(32'(q_cnt));
        push("lost_reset_high", 1);    check(32'(q_rst));
        push("lost_ready_again_edges", RC + 1 + LS);
        edges_until(SIG_RDY, 1, 100, n);
        check(32'(n));

        // Request from READY, then a second request while in RESET_HOLD.
        req = 1'b1;
        push("req_state", 0);
        push("req_count", 3);
        tick();
        req = 1'b0;
        check(32'(q_st));
        check(32'(q_cnt));
        repeat (3) tick();
        req = 1'b1;
        push("req_hold_no_increment", 3);
        tick();
        req = 1'b0;
        check(32'(q_cnt));
        push("req_hold_restart_cycles", RC);
        edges_until(SIG_RST, 0, 50, n);
        check(32'(n));
        push("req_sat_count", 3);
        check(32'(s_cnt));

        // Asynchronous reset, then lock never arrives.
        reset_n = 1'b0;
        #1;
        check_reset_values("async1");
        lock = 1'b0;
        tick();
        reset_n = 1'b1;
        push("nolock_first_reset_cycles", RC);
        edges_until(SIG_RST, 0, 50, n);
        check(32'(n));
        push("nolock_timeout_edges", LT);
        edges_until(SIG_ERR, 1, 200, n);
        check(32'(n));
        push("nolock_count_1", 1);    check(32'(q_cnt));
        push("nolock_state_hold", 0); check(32'(q_st));
        push("nolock_repulse", 1);    check(32'(q_rst));
        push("nolock_repulse_cycles", RC);
        edges_until(SIG_RST, 0, 50, n);
        check(32'(n));
        repeat (300 - (RC + LT + RC)) tick();
        push("nolock_count_at_300", 4);  check(32'(q_cnt));
        push("nolock_sat_at_300", 3);    check(32'(s_cnt));
        repeat (61) tick();
        push("nolock_count_5", 5);       check(32'(q_cnt));
        push("nolock_sat_5", 3);         check(32'(s_cnt));
        push("nolock_err_sticky", 1);    check(32'(q_err));
        repeat (19) tick();
        push("nolock_mid_wait_lock", 1); check(32'(q_st));
        reset_n = 1'b0;
        #1;
        check_reset_values("async2");

        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
